// File: rtl/apb4_archinfo_cfg.sv
// ---------------------------------------------------------------------------
// apb4_archinfo_cfg
//
// APB4 master that sequences configuration of the archinfo register slave
// and shares the single APB4 port with one host requester.
//
// A config sequence writes SYS/IDL/IDH (offsets 0x0/0x4/0x8). It then reads
// the three words back in the same order and compares each one with the
// value written. A slave error or a read-back mismatch restarts the whole
// sequence, up to RETRY_MAX extra attempts. Outside a sequence, a host
// request is granted one APB4 transfer at a time.
//
// Build option:
//   ARCHINFO_CFG_AUTO_EN  when defined, the pending-start flag resets to 1.
//                         A config sequence then begins on the first clock
//                         after presetn releases.
//
// Ports:
//   pclk, presetn        clock, asynchronous active-low reset
//   start_i              one-cycle pulse requesting a config sequence
//   host_req_i           host request level, held until host_done_o
//   host_we_i            host write (1) / read (0)
//   host_addr_i          host byte address
//   host_wdata_i         host write data
//   host_rdata_o         host read data, valid with host_done_o
//   host_done_o          one-cycle host completion pulse
//   host_err_o           pslverr of the host transfer
//   paddr_o..pwdata_o    APB4 request signals
//   prdata_i..pslverr_i  APB4 response signals
//   busy_o               config sequence in progress
//   done_o               sticky: last sequence passed
//   err_o                sticky: last sequence exhausted its retries
//
// State table:
//   IDLE     | bus idle; arbitrate config (priority) vs host
//   C_SETUP  | config step, APB setup phase
//   C_ACCESS | config step, APB access phase (waits for pready_i)
//   H_SETUP  | host transfer, APB setup phase
//   H_ACCESS | host transfer, APB access phase (waits for pready_i)
//   FAIL_CHK | config step failed; retry or give up
// ---------------------------------------------------------------------------
module apb4_archinfo_cfg #(
  parameter logic [31:0] SYS_INIT  = 32'h0000_0000,
  parameter logic [31:0] IDL_INIT  = 32'h0000_0000,
  parameter logic [31:0] IDH_INIT  = 32'h0000_0000,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        start_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [5:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic [31:0] host_rdata_o,
  output logic        host_done_o,
  output logic        host_err_o,
  output logic [5:0]  paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // Retry counter is at least 2 bits wide and grows for larger RETRY_MAX.
  localparam int unsigned RW = (RETRY_MAX < 4) ? 2 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

`ifdef ARCHINFO_CFG_AUTO_EN
  localparam logic PEND_RST = 1'b1;
`else
  localparam logic PEND_RST = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    C_SETUP  = 3'd1,
    C_ACCESS = 3'd2,
    H_SETUP  = 3'd3,
    H_ACCESS = 3'd4,
    FAIL_CHK = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [2:0]    step_q, step_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   host_rdata_q, host_rdata_d;
  logic          host_done_q, host_done_d;
  logic          host_err_q, host_err_d;
  logic [5:0]    paddr_q;
  logic          pwrite_q;
  logic [31:0]   pwdata_q;
  logic          ld_cfg, ld_host;
  logic          cfg_active;
  logic          rd_bad;

  // Steps 0-2 write SYS/IDL/IDH; steps 3-5 read the same words back.
  function automatic logic [5:0] cfg_addr(input logic [2:0] s);
    case (s)
      3'd0, 3'd3: cfg_addr = 6'h00;
      3'd1, 3'd4: cfg_addr = 6'h04;
      default:    cfg_addr = 6'h08;
    endcase
  endfunction

  function automatic logic [31:0] cfg_data(input logic [2:0] s);
    case (s)
      3'd0, 3'd3: cfg_data = SYS_INIT;
      3'd1, 3'd4: cfg_data = IDL_INIT;
      default:    cfg_data = IDH_INIT;
    endcase
  endfunction

  assign cfg_active = (state_q == C_SETUP) || (state_q == C_ACCESS) ||
                      (state_q == FAIL_CHK);
  assign rd_bad     = (step_q >= 3'd3) && (prdata_i != cfg_data(step_q));

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    step_d       = step_q;
    retry_d      = retry_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    host_rdata_d = host_rdata_q;
    host_done_d  = 1'b0;
    host_err_d   = host_err_q;
    ld_cfg       = 1'b0;
    ld_host      = 1'b0;

    // A start pulse during a running sequence is dropped; anywhere else it
    // is remembered until IDLE can act on it.
    if (start_i && !cfg_active) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        // start_i is looked at directly so that a start arriving in the same
        // cycle as a host request still wins arbitration.
        if (pend_q || start_i) begin
          state_d = C_SETUP;
          pend_d  = 1'b0;
          step_d  = 3'd0;
          retry_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ld_cfg  = 1'b1;
        end else if (host_req_i && !host_done_q) begin
          // While host_done_o is high the requester has not yet had a chance
          // to drop host_req_i, so the stale level must not be re-granted.
          state_d = H_SETUP;
          ld_host = 1'b1;
        end
      end
      C_SETUP: state_d = C_ACCESS;
      H_SETUP: state_d = H_ACCESS;
      C_ACCESS: begin
        if (pready_i) begin
          if (pslverr_i || rd_bad) begin
            state_d = FAIL_CHK;
          end else if (step_q < 3'd5) begin
            state_d = C_SETUP;
            step_d  = step_q + 3'd1;
            ld_cfg  = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      FAIL_CHK: begin
        if (retry_q < RETRY_LIM) begin
          state_d = C_SETUP;
          retry_d = retry_q + RW'(1);
          step_d  = 3'd0;
          ld_cfg  = 1'b1;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      H_ACCESS: begin
        if (pready_i) begin
          if (!pwrite_q) host_rdata_d = prdata_i;
          host_err_d  = pslverr_i;
          host_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      pend_q       <= PEND_RST;
      step_q       <= 3'd0;
      retry_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      host_rdata_q <= 32'h0;
      host_done_q  <= 1'b0;
      host_err_q   <= 1'b0;
      paddr_q      <= 6'h0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      step_q       <= step_d;
      retry_q      <= retry_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      host_rdata_q <= host_rdata_d;
      host_done_q  <= host_done_d;
      host_err_q   <= host_err_d;
      // Request fields are loaded only when entering a setup phase, so they
      // hold steady through any number of wait states.
      if (ld_cfg) begin
        paddr_q  <= cfg_addr(step_d);
        pwrite_q <= (step_d < 3'd3);
        pwdata_q <= (step_d < 3'd3) ? cfg_data(step_d) : 32'h0;
      end else if (ld_host) begin
        paddr_q  <= host_addr_i;
        pwrite_q <= host_we_i;
        pwdata_q <= host_wdata_i;
      end
    end
  end

  assign psel_o       = (state_q == C_SETUP) || (state_q == C_ACCESS) ||
                        (state_q == H_SETUP) || (state_q == H_ACCESS);
  assign penable_o    = (state_q == C_ACCESS) || (state_q == H_ACCESS);
  assign paddr_o      = paddr_q;
  assign pwrite_o     = pwrite_q;
  assign pwdata_o     = pwdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign host_rdata_o = host_rdata_q;
  assign host_done_o  = host_done_q;
  assign host_err_o   = host_err_q;

endmodule

// File: tb/tb_apb4_archinfo_cfg.sv
module tb_apb4_archinfo_cfg;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        start_i, host_req_i, host_we_i;
  logic [5:0]  host_addr_i;
  logic [31:0] host_wdata_i, host_rdata_o;
  logic        host_done_o, host_err_o;
  logic [5:0]  paddr_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] pwdata_o, prdata_i;
  logic        pready_i, pslverr_i;
  logic        busy_o, done_o, err_o;

  always #5 pclk = ~pclk;

  apb4_archinfo_cfg #(
    .SYS_INIT (32'h1234_5678),
    .IDL_INIT (32'h0000_0101),
    .IDH_INIT (32'hDEAD_BEEF),
    .RETRY_MAX(3)
  ) dut (
    .pclk(pclk), .presetn(presetn), .start_i(start_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_rdata_o(host_rdata_o),
    .host_done_o(host_done_o), .host_err_o(host_err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Slave model: programmable wait states, optional IDL corruption on the
  // first read, optional pslverr on SYS writes, and an access log.
  logic [31:0] mem [0:3];
  int          nwait;
  int          wcnt;
  logic        corrupt_en, err_sys, clr_log;
  logic        idl_bad_seen;
  int          acc_n;
  int          unstable;
  logic [6:0]  acc_log [0:63];
  logic [5:0]  h_addr;
  logic        h_wr;
  logic [31:0] h_wdata;

  assign pready_i  = psel_o && penable_o && (wcnt == nwait);
  assign prdata_i  = (corrupt_en && !idl_bad_seen && paddr_o == 6'h04) ? 32'h0
                                                                       : mem[paddr_o[3:2]];
  assign pslverr_i = pready_i && err_sys && pwrite_o && (paddr_o == 6'h00);

  always @(posedge pclk) begin
    if (clr_log) begin
      acc_n        <= 0;
      unstable     <= 0;
      idl_bad_seen <= 1'b0;
      wcnt         <= 0;
    end else begin
      if (psel_o && !penable_o) begin
        h_addr  <= paddr_o;
        h_wr    <= pwrite_o;
        h_wdata <= pwdata_o;
      end
      if (psel_o && penable_o) begin
        if (paddr_o != h_addr || pwrite_o != h_wr || pwdata_o != h_wdata)
          unstable <= unstable + 1;
        if (pready_i) begin
          wcnt <= 0;
          if (acc_n < 64) acc_log[acc_n[5:0]] <= {pwrite_o, paddr_o};
          acc_n <= acc_n + 1;
          if (pwrite_o && !pslverr_i) mem[paddr_o[3:2]] <= pwdata_o;
          if (!pwrite_o && paddr_o == 6'h04 && corrupt_en) idl_bad_seen <= 1'b1;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    tick();
    clr_log = 1'b0;
  endtask

  // Pulse start_i in IDLE; returns in cycle 0 of the sequence (C_SETUP).
  task automatic start_seq();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    while (!(done_o || err_o) && cyc < 400) begin
      tick();
      cyc++;
    end
    if (cyc >= 400) check("seq_timeout", 32'(cyc), 32'd0);
  endtask

  logic [6:0] exp_log [0:5];
  int c, h;

  initial begin
    exp_log[0] = 7'h40; exp_log[1] = 7'h44; exp_log[2] = 7'h48;
    exp_log[3] = 7'h00; exp_log[4] = 7'h04; exp_log[5] = 7'h08;

    presetn = 1'b0; start_i = 1'b0; host_req_i = 1'b0; host_we_i = 1'b0;
    host_addr_i = 6'h0; host_wdata_i = 32'h0;
    nwait = 0; corrupt_en = 1'b0; err_sys = 1'b0; clr_log = 1'b1;
    repeat (3) tick();
    check("reset_bus", {29'h0, psel_o, penable_o, busy_o}, 32'h0);
    check("reset_status", {28'h0, done_o, err_o, host_done_o, host_err_o}, 32'h0);
    presetn = 1'b1;
    tick();
`ifdef ARCHINFO_CFG_AUTO_EN
    clr_log = 1'b0;
    wait_end(c);
    check("auto_boot_done", {31'h0, done_o}, 32'd1);
`endif
    clr_log = 1'b0;
    tick();

    // Zero-wait sequence
    clear_log();
    start_seq();
    check("t1_c0", {29'h0, psel_o, penable_o, busy_o}, 32'h5);
    wait_end(c);
    check("t1_latency", 32'(c), 32'd12);
    check("t1_status", {29'h0, done_o, err_o, busy_o}, 32'h4);
    check("t1_acc_n", 32'(acc_n), 32'd6);
    for (int i = 0; i < 6; i++) check("t1_order", {25'h0, acc_log[i]}, {25'h0, exp_log[i]});

    // Two wait states per access
    nwait = 2;
    clear_log();
    start_seq();
    wait_end(c);
    check("t2_latency", 32'(c), 32'd24);
    check("t2_stable", 32'(unstable), 32'd0);
    check("t2_done", {31'h0, done_o}, 32'd1);
    nwait = 0;

    // IDL read-back corrupted on the first attempt
    corrupt_en = 1'b1;
    clear_log();
    start_seq();
    wait_end(c);
    check("t3_acc_n", 32'(acc_n), 32'd11);
    check("t3_latency", 32'(c), 32'd23);
    check("t3_status", {30'h0, done_o, err_o}, 32'h2);
    corrupt_en = 1'b0;

    // pslverr on every SYS write: four attempts, then error
    err_sys = 1'b1;
    clear_log();
    start_seq();
    wait_end(c);
    check("t4_acc_n", 32'(acc_n), 32'd4);
    check("t4_latency", 32'(c), 32'd12);
    check("t4_status", {29'h0, done_o, err_o, busy_o}, 32'h2);
    err_sys = 1'b0;

    // Start and host read of 0x8 in the same IDLE cycle
    clear_log();
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 6'h08;
    start_seq();
    check("t5_cfg_first", {23'h0, psel_o, penable_o, pwrite_o, paddr_o}, 32'h140);
    wait_end(c);
    check("t5_done", {31'h0, done_o}, 32'd1);
    h = 0;
    while (!host_done_o && h < 50) begin
      tick();
      h++;
    end
    check("t5_host_lat", 32'(h), 32'd3);
    check("t5_host_rdata", host_rdata_o, 32'hDEAD_BEEF);
    check("t5_host_err", {31'h0, host_err_o}, 32'd0);
    host_req_i = 1'b0;
    tick();
    check("t5_done_pulse", {31'h0, host_done_o}, 32'd0);
    check("t5_host_acc", {25'h0, acc_log[6]}, 32'h08);

    // Host write; start pulse during it is served after host_done_o
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 6'h04; host_wdata_i = 32'h0000_0101;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("t6_host_done", {31'h0, host_done_o}, 32'd1);
    check("t6_rdata_keep", host_rdata_o, 32'hDEAD_BEEF);
    host_req_i = 1'b0;
    tick();
    check("t6_deferred", {29'h0, psel_o, penable_o, busy_o}, 32'h5);
    wait_end(c);
    check("t6_latency", 32'(c), 32'd12);

    // Start pulse during a running sequence is ignored
    start_seq();
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_end(c);
    tick();
    tick();
    check("t7_ignored", {30'h0, psel_o, busy_o}, 32'h0);

    // Reset during step 4 C_ACCESS
    start_seq();
    repeat (9) tick();
    check("t8_step4", {23'h0, psel_o, penable_o, pwrite_o, paddr_o}, 32'h184);
    presetn = 1'b0;
    #1;
    check("t8_bus", {30'h0, psel_o, penable_o}, 32'h0);
    check("t8_status", {27'h0, busy_o, done_o, err_o, host_done_o, host_err_o}, 32'h0);
    check("t8_rdata", host_rdata_o, 32'h0);
    #2;
    presetn = 1'b1;
    tick();
`ifdef ARCHINFO_CFG_AUTO_EN
    check("t8_restart", {23'h0, psel_o, penable_o, pwrite_o, paddr_o}, 32'h140);
    wait_end(c);
    check("t8_restart_done", {31'h0, done_o}, 32'd1);
`else
    tick();
    tick();
    check("t8_no_resume", {30'h0, psel_o, busy_o}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
